// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding and default sizing.
package dmem_arbiter_pkg;

  localparam int DEFAULT_WIDTH     = 32;
  localparam int DEFAULT_BURST_MAX = 4;

  // LAST0/LAST1 remember the last granted port; BURST1 holds a locked port-1 burst.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAST0  = 2'd1,
    ST_LAST1  = 2'd2,
    ST_BURST1 = 2'd3
  } arb_state_t;

endpackage

// File: rtl/dmem_port_mux.sv
// 2:1 selector for the address/data/qualifier bundle; drives all zeros when neither side is selected.
module dmem_port_mux #(
  parameter int WIDTH = 32
) (
  input  logic             sel0,
  input  logic             sel1,
  input  logic [0:WIDTH-1] p0_addr,
  input  logic [0:WIDTH-1] p0_data,
  input  logic             p0_write_enable,
  input  logic             p0_byte,
  input  logic             p0_half_word,
  input  logic             p0_sign_extend,
  input  logic [0:WIDTH-1] p1_addr,
  input  logic [0:WIDTH-1] p1_data,
  input  logic             p1_write_enable,
  input  logic             p1_byte,
  input  logic             p1_half_word,
  input  logic             p1_sign_extend,
  output logic [0:WIDTH-1] addr_out,
  output logic [0:WIDTH-1] data_out,
  output logic             write_enable_out,
  output logic             byte_out,
  output logic             half_word_out,
  output logic             sign_extend_out
);

  always_comb begin
    addr_out         = '0;
    data_out         = '0;
    write_enable_out = 1'b0;
    byte_out         = 1'b0;
    half_word_out    = 1'b0;
    sign_extend_out  = 1'b0;
    if (sel0) begin
      addr_out         = p0_addr;
      data_out         = p0_data;
      write_enable_out = p0_write_enable;
      byte_out         = p0_byte;
      half_word_out    = p0_half_word;
      sign_extend_out  = p0_sign_extend;
    end else if (sel1) begin
      addr_out         = p1_addr;
      data_out         = p1_data;
      write_enable_out = p1_write_enable;
      byte_out         = p1_byte;
      half_word_out    = p1_half_word;
      sign_extend_out  = p1_sign_extend;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: zero-latency grants, round-robin on contention,
// and bounded port-1 locked bursts so the processor port cannot starve.
// Handshake: a port holds req (and its qualifiers) stable until it sees its grant;
// a granted access completes in that same cycle, read data is valid while granted.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int BURST_MAX = DEFAULT_BURST_MAX
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             p0_req,
  input  logic             p0_write_enable,
  input  logic             p0_byte,
  input  logic             p0_half_word,
  input  logic             p0_sign_extend,
  input  logic [0:WIDTH-1] p0_addr,
  input  logic [0:WIDTH-1] p0_data_in,
  output logic             p0_grant,
  output logic             p0_stall,
  input  logic             p1_req,
  input  logic             p1_lock,
  input  logic             p1_write_enable,
  input  logic             p1_byte,
  input  logic             p1_half_word,
  input  logic             p1_sign_extend,
  input  logic [0:WIDTH-1] p1_addr,
  input  logic [0:WIDTH-1] p1_data_in,
  output logic             p1_grant,
  output logic [0:WIDTH-1] addr_to_mem,
  output logic [0:WIDTH-1] data_to_mem,
  output logic             write_enable_to_mem,
  output logic             byte_to_mem,
  output logic             half_word_to_mem,
  output logic             sign_extend_to_mem,
  input  logic [0:WIDTH-1] data_from_mem,
  output logic [0:WIDTH-1] p0_data_out,
  output logic [0:WIDTH-1] p1_data_out
);

  localparam int CW = $clog2(BURST_MAX + 1);

  arb_state_t    state, state_next;
  logic [CW-1:0] burst_cnt, burst_cnt_next;
  logic          grant0, grant1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      burst_cnt <= '0;
    end else begin
      state     <= state_next;
      burst_cnt <= burst_cnt_next;
    end
  end

  always_comb begin
    grant0         = 1'b0;
    grant1         = 1'b0;
    state_next     = state;
    burst_cnt_next = burst_cnt;

    if (!p0_req && !p1_req) begin
      state_next     = ST_IDLE;
      burst_cnt_next = '0;
    end else if (state == ST_BURST1 && p1_req && p1_lock) begin
      // Locked burst keeps port 1 until the waiting processor has been passed over BURST_MAX times.
      if (p0_req && burst_cnt == CW'(BURST_MAX)) begin
        grant0 = 1'b1;
      end else begin
        grant1 = 1'b1;
      end
    end else begin
      if (state == ST_BURST1) begin
        burst_cnt_next = '0;
      end
      if (p0_req && p1_req) begin
        if (state == ST_LAST0) begin
          grant1 = 1'b1;
        end else begin
          grant0 = 1'b1;
        end
      end else if (p0_req) begin
        grant0 = 1'b1;
      end else begin
        grant1 = 1'b1;
      end
    end

    // Every locked port-1 grant made while port 0 waits counts against the burst budget.
    if (grant0) begin
      state_next     = ST_LAST0;
      burst_cnt_next = '0;
    end else if (grant1) begin
      if (p1_lock) begin
        state_next = ST_BURST1;
        if (p0_req) begin
          burst_cnt_next = burst_cnt_next + CW'(1);
        end
      end else begin
        state_next     = ST_LAST1;
        burst_cnt_next = '0;
      end
    end

    if (reset) begin
      grant0 = 1'b0;
      grant1 = 1'b0;
    end
  end

  assign p0_grant    = grant0;
  assign p1_grant    = grant1;
  assign p0_stall    = p0_req & ~grant0 & ~reset;
  assign p0_data_out = data_from_mem;
  assign p1_data_out = data_from_mem;

  dmem_port_mux #(
    .WIDTH(WIDTH)
  ) u_port_mux (
    .sel0            (grant0),
    .sel1            (grant1),
    .p0_addr         (p0_addr),
    .p0_data         (p0_data_in),
    .p0_write_enable (p0_write_enable),
    .p0_byte         (p0_byte),
    .p0_half_word    (p0_half_word),
    .p0_sign_extend  (p0_sign_extend),
    .p1_addr         (p1_addr),
    .p1_data         (p1_data_in),
    .p1_write_enable (p1_write_enable),
    .p1_byte         (p1_byte),
    .p1_half_word    (p1_half_word),
    .p1_sign_extend  (p1_sign_extend),
    .addr_out        (addr_to_mem),
    .data_out        (data_to_mem),
    .write_enable_out(write_enable_to_mem),
    .byte_out        (byte_to_mem),
    .half_word_out   (half_word_to_mem),
    .sign_extend_out (sign_extend_to_mem)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small byte-addressed big-endian memory model.
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        p0_req, p0_write_enable, p0_byte, p0_half_word, p0_sign_extend;
  logic [0:31] p0_addr, p0_data_in;
  logic        p0_grant, p0_stall;
  logic        p1_req, p1_lock, p1_write_enable, p1_byte, p1_half_word, p1_sign_extend;
  logic [0:31] p1_addr, p1_data_in;
  logic        p1_grant;
  logic [0:31] addr_to_mem, data_to_mem;
  logic        write_enable_to_mem, byte_to_mem, half_word_to_mem, sign_extend_to_mem;
  logic [0:31] data_from_mem;
  logic [0:31] p0_data_out, p1_data_out;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  mem [0:1023];
  logic [31:0] m_addr, m_data, m_rd;
  logic [9:0]  m_idx;

  always #5 clock = ~clock;

  dmem_arbiter dut (
    .clock(clock), .reset(reset),
    .p0_req(p0_req), .p0_write_enable(p0_write_enable), .p0_byte(p0_byte),
    .p0_half_word(p0_half_word), .p0_sign_extend(p0_sign_extend),
    .p0_addr(p0_addr), .p0_data_in(p0_data_in),
    .p0_grant(p0_grant), .p0_stall(p0_stall),
    .p1_req(p1_req), .p1_lock(p1_lock), .p1_write_enable(p1_write_enable), .p1_byte(p1_byte),
    .p1_half_word(p1_half_word), .p1_sign_extend(p1_sign_extend),
    .p1_addr(p1_addr), .p1_data_in(p1_data_in), .p1_grant(p1_grant),
    .addr_to_mem(addr_to_mem), .data_to_mem(data_to_mem),
    .write_enable_to_mem(write_enable_to_mem), .byte_to_mem(byte_to_mem),
    .half_word_to_mem(half_word_to_mem), .sign_extend_to_mem(sign_extend_to_mem),
    .data_from_mem(data_from_mem),
    .p0_data_out(p0_data_out), .p1_data_out(p1_data_out)
  );

  // Combinational read path of the memory model
  always @* begin
    m_addr = addr_to_mem;
    m_idx  = m_addr[9:0];
    if (byte_to_mem) begin
      m_rd = sign_extend_to_mem ? {{24{mem[m_idx][7]}}, mem[m_idx]} : {24'h0, mem[m_idx]};
    end else if (half_word_to_mem) begin
      m_rd = {mem[{m_idx[9:1], 1'b0}], mem[{m_idx[9:1], 1'b1}]};
      if (sign_extend_to_mem) m_rd = {{16{m_rd[15]}}, m_rd[15:0]};
      else                    m_rd = {16'h0, m_rd[15:0]};
    end else begin
      m_rd = {mem[{m_idx[9:2], 2'd0}], mem[{m_idx[9:2], 2'd1}],
              mem[{m_idx[9:2], 2'd2}], mem[{m_idx[9:2], 2'd3}]};
    end
    data_from_mem = m_rd;
  end

  always @(posedge clock) begin
    m_data = data_to_mem;
    if (write_enable_to_mem) begin
      if (byte_to_mem) begin
        mem[m_idx] <= m_data[7:0];
      end else if (half_word_to_mem) begin
        mem[{m_idx[9:1], 1'b0}] <= m_data[15:8];
        mem[{m_idx[9:1], 1'b1}] <= m_data[7:0];
      end else begin
        mem[{m_idx[9:2], 2'd0}] <= m_data[31:24];
        mem[{m_idx[9:2], 2'd1}] <= m_data[23:16];
        mem[{m_idx[9:2], 2'd2}] <= m_data[15:8];
        mem[{m_idx[9:2], 2'd3}] <= m_data[7:0];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    p0_req = 0; p0_write_enable = 0; p0_byte = 0; p0_half_word = 0; p0_sign_extend = 0;
    p0_addr = '0; p0_data_in = '0;
    p1_req = 0; p1_lock = 0; p1_write_enable = 0; p1_byte = 0; p1_half_word = 0; p1_sign_extend = 0;
    p1_addr = '0; p1_data_in = '0;
  endtask

  // Inputs change after the falling edge; outputs are observed 1ns later, well before the rising edge.
  task automatic setup_cycle();
    @(negedge clock);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_grants(input string tag, input logic g0, input logic g1, input logic st);
    chk({tag, "_p0_grant"}, {31'b0, p0_grant}, {31'b0, g0});
    chk({tag, "_p1_grant"}, {31'b0, p1_grant}, {31'b0, g1});
    chk({tag, "_p0_stall"}, {31'b0, p0_stall}, {31'b0, st});
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    clear_inputs();
    reset = 1'b1;

    // Reset with both ports requesting writes
    setup_cycle();
    p0_req = 1; p0_write_enable = 1; p0_addr = 32'h40; p0_data_in = 32'hDEADBEEF;
    p1_req = 1; p1_write_enable = 1; p1_addr = 32'h44; p1_data_in = 32'hCAFEF00D;
    settle();
    chk_grants("rst", 0, 0, 0);
    chk("rst_we", {31'b0, write_enable_to_mem}, 32'h0);
    chk("rst_addr", addr_to_mem, 32'h0);
    chk("rst_data", data_to_mem, 32'h0);

    // Port-0 word write, then read back
    setup_cycle();
    reset = 1'b0;
    clear_inputs();
    p0_req = 1; p0_write_enable = 1; p0_addr = 32'h100; p0_data_in = 32'h12345678;
    settle();
    chk_grants("wr0", 1, 0, 0);
    chk("wr0_we", {31'b0, write_enable_to_mem}, 32'h1);
    chk("wr0_addr", addr_to_mem, 32'h100);
    chk("wr0_data", data_to_mem, 32'h12345678);

    setup_cycle();
    p0_write_enable = 0; p0_data_in = '0;
    settle();
    chk_grants("rd0", 1, 0, 0);
    chk("rd0_data", p0_data_out, 32'h12345678);
    chk("rd0_p1copy", p1_data_out, 32'h12345678);

    setup_cycle();
    clear_inputs();
    settle();
    chk_grants("idle", 0, 0, 0);
    chk("idle_addr", addr_to_mem, 32'h0);

    // Round-robin: both read for four cycles from IDLE
    setup_cycle();
    p0_req = 1; p0_addr = 32'h100;
    p1_req = 1; p1_addr = 32'h104;
    settle();
    chk_grants("rr1", 1, 0, 0);
    chk("rr1_addr", addr_to_mem, 32'h100);
    setup_cycle(); settle();
    chk_grants("rr2", 0, 1, 1);
    chk("rr2_addr", addr_to_mem, 32'h104);
    setup_cycle(); settle();
    chk_grants("rr3", 1, 0, 0);
    setup_cycle(); settle();
    chk_grants("rr4", 0, 1, 1);

    // Burst: park in LAST0, then p1 locked writes against a waiting p0
    setup_cycle();
    p1_req = 0;
    settle();
    chk_grants("pre_burst", 1, 0, 0);
    setup_cycle();
    p1_req = 1; p1_lock = 1; p1_write_enable = 1; p1_addr = 32'h300; p1_data_in = 32'h11112222;
    settle();
    chk_grants("bu1", 0, 1, 1);
    chk("bu1_we", {31'b0, write_enable_to_mem}, 32'h1);
    setup_cycle(); settle();
    chk_grants("bu2", 0, 1, 1);
    setup_cycle(); settle();
    chk_grants("bu3", 0, 1, 1);
    setup_cycle(); settle();
    chk_grants("bu4", 0, 1, 1);
    setup_cycle(); settle();
    chk_grants("bu5", 1, 0, 0);
    chk("bu5_we", {31'b0, write_enable_to_mem}, 32'h0);
    setup_cycle(); settle();
    chk_grants("bu6", 0, 1, 1);

    setup_cycle();
    clear_inputs();
    settle();
    chk_grants("bu_end", 0, 0, 0);

    // Reset in the third cycle of a burst
    setup_cycle();
    p1_req = 1; p1_lock = 1; p1_write_enable = 1; p1_addr = 32'h3E0; p1_data_in = 32'h55556666;
    settle();
    chk_grants("rb1", 0, 1, 0);
    setup_cycle();
    p0_req = 1; p0_addr = 32'h100;
    settle();
    chk_grants("rb2", 0, 1, 1);
    setup_cycle();
    reset = 1'b1; p1_addr = 32'h3F0; p1_data_in = 32'h77778888;
    settle();
    chk_grants("rb3", 0, 0, 0);
    chk("rb3_we", {31'b0, write_enable_to_mem}, 32'h0);
    chk("rb3_addr", addr_to_mem, 32'h0);
    setup_cycle();
    reset = 1'b0; p1_write_enable = 0;
    settle();
    chk_grants("rb_after", 1, 0, 0);
    setup_cycle();
    clear_inputs();
    p0_req = 1; p0_addr = 32'h3F0;
    settle();
    chk("rb_nowrite", p0_data_out, 32'h0);

    // Byte write with sign extension, then byte/half reads
    setup_cycle();
    clear_inputs();
    p1_req = 1; p1_write_enable = 1; p1_byte = 1; p1_sign_extend = 1;
    p1_addr = 32'h203; p1_data_in = 32'h000000AB;
    settle();
    chk_grants("bw", 0, 1, 0);
    chk("bw_byte", {31'b0, byte_to_mem}, 32'h1);
    chk("bw_sext", {31'b0, sign_extend_to_mem}, 32'h1);
    chk("bw_we", {31'b0, write_enable_to_mem}, 32'h1);

    setup_cycle();
    p0_req = 1; p0_byte = 1; p0_sign_extend = 1; p0_addr = 32'h203;
    p1_write_enable = 0; p1_byte = 0; p1_half_word = 1; p1_sign_extend = 0; p1_addr = 32'h202;
    settle();
    chk_grants("br0", 1, 0, 0);
    chk("br0_byte", {31'b0, byte_to_mem}, 32'h1);
    chk("br0_half", {31'b0, half_word_to_mem}, 32'h0);
    chk("br0_sext", {31'b0, sign_extend_to_mem}, 32'h1);
    chk("br0_data", p0_data_out, 32'hFFFFFFAB);

    setup_cycle(); settle();
    chk_grants("hr1", 0, 1, 1);
    chk("hr1_byte", {31'b0, byte_to_mem}, 32'h0);
    chk("hr1_half", {31'b0, half_word_to_mem}, 32'h1);
    chk("hr1_sext", {31'b0, sign_extend_to_mem}, 32'h0);
    chk("hr1_data", p1_data_out, 32'h000000AB);

    setup_cycle();
    clear_inputs();
    settle();
    chk_grants("final_idle", 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, sets the address and data width; all buses are declared [0:WIDTH-1], with bit 0 as the MSB.
REQ-002 Parameter BURST_MAX, default 4, sets the maximum number of consecutive port-1 locked grants while port 0 waits.
REQ-003 clock  input  1  single clock; memory writes commit on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 p0_req, p0_write_enable, p0_byte, p0_half_word, p0_sign_extend  input  1 each  port 0 (processor) request and access qualifiers.
REQ-006 p0_addr, p0_data_in  input  WIDTH each  port 0 address and write data.
REQ-007 p0_grant, p0_stall  output  1 each  port 0 access granted this cycle; port 0 must hold its request.
REQ-008 p1_req, p1_lock, p1_write_enable, p1_byte, p1_half_word, p1_sign_extend  input  1 each  port 1 (loader/debug) request, burst lock and qualifiers.
REQ-009 p1_addr, p1_data_in  input  WIDTH each  port 1 address and write data.
REQ-010 p1_grant  output  1  port 1 access granted this cycle.
REQ-011 addr_to_mem, data_to_mem  output  WIDTH each  muxed address and write data to dmem.
REQ-012 write_enable_to_mem, byte_to_mem, half_word_to_mem, sign_extend_to_mem  output  1 each  muxed qualifiers to dmem.
REQ-013 data_from_mem  input  WIDTH  dmem read data (combinational).
REQ-014 p0_data_out, p1_data_out  output  WIDTH each  copies of data_from_mem.

Function
REQ-015 Grants SHALL be combinational from the requests and the registered state, so a granted access completes in the same cycle (zero-cycle arbitration latency).
REQ-016 At most one of p0_grant and p1_grant SHALL be high; a grant SHALL only be asserted for a port whose req is high.
REQ-017 The state machine SHALL have the states IDLE, LAST0, LAST1 and BURST1, where LASTn records the last granted port.
REQ-018 If only one port requests, that port SHALL be granted.
REQ-019 If both ports request in IDLE or LAST1, port 0 SHALL be granted; if both request in LAST0, port 1 SHALL be granted (round-robin).
REQ-020 A port-1 grant with p1_lock high SHALL transition to BURST1; in BURST1 with p1_req and p1_lock high, port 1 SHALL keep the grant regardless of p0_req.
REQ-021 A burst counter (clog2(BURST_MAX+1) bits) SHALL increment on each BURST1 grant made while p0_req is high.
REQ-022 When the burst counter equals BURST_MAX and p0_req is high, port 0 SHALL be granted; the counter SHALL clear and the state SHALL become LAST0.
REQ-023 Dropping p1_lock or p1_req in BURST1 SHALL clear the counter and apply the REQ-018/019 rules from LAST1.
REQ-024 No request SHALL move the state to IDLE and clear the counter.
REQ-025 The memory-side outputs SHALL carry the granted port's signals; with no grant, addr_to_mem and data_to_mem SHALL be 0 and all four qualifiers SHALL be 0.
REQ-026 p0_stall SHALL equal p0_req AND NOT p0_grant.
REQ-027 p0_data_out and p1_data_out SHALL always equal data_from_mem; the requester qualifies the data with its grant.

Reset
REQ-028 While reset is high, both grants, p0_stall, write_enable_to_mem and all memory-side outputs SHALL be 0, independent of the requests.
REQ-029 On the first clock edge with reset high, the state SHALL become IDLE and the burst counter SHALL clear; an in-progress burst SHALL be abandoned and no write SHALL reach dmem during reset.

Structure
REQ-030 The state encoding (IDLE, LAST0, LAST1, BURST1) and the default WIDTH and BURST_MAX values SHALL be defined as shared constants in the project definitions include.
REQ-031 The arbiter SHALL contain one sub-module, dmem_port_mux, a WIDTH-parameterised 2:1 mux for the address, data and qualifier bundle.

Verification
REQ-032 Only p0_req, write 0x12345678 to address 0x100 -> p0_grant=1, write_enable_to_mem=1, p0_stall=0; a later port-0 read of 0x100 returns 0x12345678.
REQ-033 Both ports request reads for 4 cycles with no lock, starting from IDLE -> grant order is p0, p1, p0, p1, and p0_stall is high exactly in cycles 2 and 4.
REQ-034 With BURST_MAX=4, p1_lock held, p1 writing and p0_req held -> p1 is granted 4 cycles, p0 in cycle 5, and p1 resumes in cycle 6.
REQ-035 Reset asserted during the third cycle of a p1 burst -> grants and write_enable_to_mem are 0 that cycle; after release with both requesting, p0 is granted first.
REQ-036 A p1 byte write of 0xAB to 0x203 with sign extend, then a p0 byte read of 0x203 -> byte_to_mem and sign_extend_to_mem follow the granted port, and p0_data_out=0xFFFFFFAB.
